defuse_ctl: RTL and testbench
=============================

Name: defuse_ctl

Overview:
- Owns the per-level defuse (flag) arrays that the board renderer reads, plus the remaining-flag counter.
- Accepts right-click flag-toggle requests in board field coordinates, checks with the board state whether the field is already revealed, then sets or clears its defuse bit.
- Sits between the mouse/field-index logic and the board draw chain; its arrays feed the defused-field renderer directly.

Parameters:
- MINES_EASY, 10, mine count (and flag budget) for level 1, 8x8 board
- MINES_MEDIUM, 20, mine count for level 2, 10x10 board
- MINES_HARD, 40, mine count for level 3, 16x16 board

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- level  in  2  0 = no game, 1 = easy, 2 = medium, 3 = hard
- game_active  in  1  high while play is allowed; requests ignored when low
- new_game  in  1  single-cycle pulse; clears arrays, reloads budget
- flag_req  in  1  single-cycle toggle request
- flag_x  in  4  field column index of request
- flag_y  in  4  field row index of request
- rev_en  out  1  lookup strobe to board-state store
- rev_x  out  4  lookup column
- rev_y  out  4  lookup row
- revealed_in  in  1  revealed status of (rev_x, rev_y); valid the cycle after rev_en
- busy  out  1  high while a request is in flight
- flag_done  out  1  one-cycle completion pulse
- flag_ok  out  1  qualifies flag_done: 1 = array changed, 0 = refused
- flags_left  out  8  remaining flags
- defuse_arr_easy  out  [7:0][7:0]  defuse bits, indexed [x][y]
- defuse_arr_medium  out  [9:0][9:0]  defuse bits, indexed [x][y]
- defuse_arr_hard  out  [15:0][15:0]  defuse bits, indexed [x][y]

Behaviour:
- Reset (async, rst_n low):
  - All arrays 0; flags_left 0.
  - busy, flag_done, flag_ok, rev_en all 0; rev_x and rev_y 0.
  - FSM to IDLE.
- All outputs are registered.
- FSM states IDLE, LOOKUP, UPDATE.
- IDLE:
  - Accept flag_req only if game_active=1, level != 0, flag_x < N and flag_y < N, where N = 8, 10 or 16 by level.
  - On accept: latch x/y into rev_x/rev_y, go to LOOKUP.
  - Rejected requests produce no flag_done and no state change.
- LOOKUP (one cycle): rev_en=1, busy=1. Go to UPDATE.
- UPDATE (one cycle):
  - busy=1. Sample revealed_in.
  - Let b = current defuse bit of the active-level array at [rev_x][rev_y].
  - revealed_in=1: no change, flag_ok=0.
  - b=1: clear the bit, flags_left+1, flag_ok=1.
  - b=0 and flags_left>0: set the bit, flags_left-1, flag_ok=1.
  - b=0 and flags_left=0: no change, flag_ok=0.
  - Go to IDLE.
- Timing:
  - Array and flags_left updates, flag_done=1 and flag_ok are all registered at the edge that ends UPDATE.
  - A request sampled at edge E0 completes at E2; flag_done is high E2..E3.
  - busy is high E0..E2 (2 cycles). flag_ok holds its value until the next flag_done.
- flag_req while busy: ignored, not queued.
- Only the array selected by level is ever modified.
- flags_left never exceeds the level's mine count and never wraps below 0.
- new_game (takes priority over everything):
  - All three arrays cleared in one cycle.
  - flags_left = MINES_<level> (0 if level=0).
  - FSM to IDLE; any in-flight request is aborted without flag_done.
  - busy and rev_en drop the next cycle.
- new_game and flag_req in the same cycle: new_game wins, request dropped.
- Change of level while no new_game is given: treated as new_game (clear and reload); detected by a registered compare of level.
- game_active falling mid-request: the in-flight request still completes; new requests are refused.
- reset mid-request: immediate return to reset values; no flag_done.

Test Plan:
- Reset, level=1, new_game -> flags_left=10, all arrays 0, busy=0.
- flag_req (3,5), revealed_in=0 -> rev_en high 1 cycle after request; at +2 cycles defuse_arr_easy[3][5]=1, flags_left=9, flag_done=1, flag_ok=1. Repeat same request -> bit 0, flags_left=10.
- flag_req (2,2) with revealed_in=1 -> flag_done=1, flag_ok=0, array and flags_left unchanged.
- level=2, place 20 flags on distinct fields, then a 21st request -> flags_left=0, 21st gives flag_ok=0. Unflag one -> flags_left=1.
- level=1, flag_req (9,0) -> ignored, no rev_en, no flag_done. Second flag_req issued while busy -> ignored.
- Mid-request (during LOOKUP) assert new_game at level=3 -> no flag_done, arrays 0, flags_left=40. Also: rst_n low during UPDATE -> all outputs 0.

Source files
------------

// File: rtl/defuse_ctl_if.sv
// Flag-request handshake between the field-index logic and defuse_ctl,
// together with the revealed-status lookup towards the board-state store.
interface defuse_ctl_if;
  logic       flag_req;
  logic [3:0] flag_x;
  logic [3:0] flag_y;
  logic       busy;
  logic       flag_done;
  logic       flag_ok;
  logic       rev_en;
  logic [3:0] rev_x;
  logic [3:0] rev_y;
  logic       revealed_in;

  modport master (
    output flag_req, flag_x, flag_y, revealed_in,
    input  busy, flag_done, flag_ok, rev_en, rev_x, rev_y
  );

  modport slave (
    input  flag_req, flag_x, flag_y, revealed_in,
    output busy, flag_done, flag_ok, rev_en, rev_x, rev_y
  );
endinterface

// File: rtl/defuse_ctl.sv
// Per-level defuse (flag) arrays and remaining-flag counter; toggles a flag
// after checking with the board store that the field is not yet revealed.
module defuse_ctl #(
  parameter int MINES_EASY   = 10,
  parameter int MINES_MEDIUM = 20,
  parameter int MINES_HARD   = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         level,
  input  logic               game_active,
  input  logic               new_game,
  defuse_ctl_if.slave        bus,
  output logic [7:0]         flags_left,
  output logic [7:0][7:0]    defuse_arr_easy,
  output logic [9:0][9:0]    defuse_arr_medium,
  output logic [15:0][15:0]  defuse_arr_hard
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, UPDATE = 2'd2} state_t;

  state_t     state_r;
  logic [1:0] level_r;
  logic       restart_s;
  logic       in_range_s;
  logic       accept_s;
  logic       cur_bit_s;
  logic       do_write_s;

  function automatic logic [7:0] mines_for(input logic [1:0] lvl);
    case (lvl)
      2'd1:    mines_for = 8'(MINES_EASY);
      2'd2:    mines_for = 8'(MINES_MEDIUM);
      2'd3:    mines_for = 8'(MINES_HARD);
      default: mines_for = 8'd0;
    endcase
  endfunction

  // A level switch without new_game is treated exactly like new_game.
  assign restart_s  = new_game || (level != level_r);
  assign accept_s   = bus.flag_req && game_active && in_range_s;
  assign do_write_s = !bus.revealed_in && (cur_bit_s || (flags_left != 8'd0));

  // Request coordinate bounds for the active board size.
  always_comb begin
    in_range_s = 1'b0;
    case (level)
      2'd1:    in_range_s = (bus.flag_x < 4'd8)  && (bus.flag_y < 4'd8);
      2'd2:    in_range_s = (bus.flag_x < 4'd10) && (bus.flag_y < 4'd10);
      2'd3:    in_range_s = 1'b1;
      default: in_range_s = 1'b0;
    endcase
  end

  // Current defuse bit of the latched field in the active-level array.
  always_comb begin
    cur_bit_s = 1'b0;
    case (level)
      2'd1:    cur_bit_s = defuse_arr_easy[bus.rev_x[2:0]][bus.rev_y[2:0]];
      2'd2:    cur_bit_s = defuse_arr_medium[bus.rev_x][bus.rev_y];
      2'd3:    cur_bit_s = defuse_arr_hard[bus.rev_x][bus.rev_y];
      default: cur_bit_s = 1'b0;
    endcase
  end

  // Request FSM with registered handshake outputs, arrays and flag counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= IDLE;
      level_r           <= 2'd0;
      flags_left        <= 8'd0;
      defuse_arr_easy   <= '0;
      defuse_arr_medium <= '0;
      defuse_arr_hard   <= '0;
      bus.busy          <= 1'b0;
      bus.flag_done     <= 1'b0;
      bus.flag_ok       <= 1'b0;
      bus.rev_en        <= 1'b0;
      bus.rev_x         <= 4'd0;
      bus.rev_y         <= 4'd0;
    end else begin
      level_r       <= level;
      bus.flag_done <= 1'b0;
      if (restart_s) begin
        state_r           <= IDLE;
        flags_left        <= mines_for(level);
        defuse_arr_easy   <= '0;
        defuse_arr_medium <= '0;
        defuse_arr_hard   <= '0;
        bus.busy          <= 1'b0;
        bus.rev_en        <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (accept_s) begin
              bus.rev_x  <= bus.flag_x;
              bus.rev_y  <= bus.flag_y;
              bus.rev_en <= 1'b1;
              bus.busy   <= 1'b1;
              state_r    <= LOOKUP;
            end else begin
              bus.rev_en <= 1'b0;
              bus.busy   <= 1'b0;
            end
          end
          LOOKUP: begin
            bus.rev_en <= 1'b0;
            state_r    <= UPDATE;
          end
          UPDATE: begin
            bus.busy      <= 1'b0;
            bus.flag_done <= 1'b1;
            bus.flag_ok   <= do_write_s;
            state_r       <= IDLE;
            if (do_write_s) begin
              flags_left <= cur_bit_s ? (flags_left + 8'd1) : (flags_left - 8'd1);
              case (level)
                2'd1:    defuse_arr_easy[bus.rev_x[2:0]][bus.rev_y[2:0]] <= !cur_bit_s;
                2'd2:    defuse_arr_medium[bus.rev_x][bus.rev_y] <= !cur_bit_s;
                2'd3:    defuse_arr_hard[bus.rev_x][bus.rev_y] <= !cur_bit_s;
                default: flags_left <= flags_left;
              endcase
            end else begin
              flags_left <= flags_left;
            end
          end
          default: begin
            state_r    <= IDLE;
            bus.busy   <= 1'b0;
            bus.rev_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_defuse_ctl.sv
// Directed self-checking bench for defuse_ctl with hand-computed expectations.
module tb_defuse_ctl;
  logic               clk;
  logic               rst_n;
  logic [1:0]         level;
  logic               game_active;
  logic               new_game;
  logic [7:0]         flags_left;
  logic [7:0][7:0]    defuse_arr_easy;
  logic [9:0][9:0]    defuse_arr_medium;
  logic [15:0][15:0]  defuse_arr_hard;

  logic [7:0][7:0]    exp_easy;
  logic [9:0][9:0]    exp_med;
  logic [15:0][15:0]  exp_hard;

  int n_checks;
  int n_errors;

  defuse_ctl_if bus ();

  defuse_ctl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .level             (level),
    .game_active       (game_active),
    .new_game          (new_game),
    .bus               (bus),
    .flags_left        (flags_left),
    .defuse_arr_easy   (defuse_arr_easy),
    .defuse_arr_medium (defuse_arr_medium),
    .defuse_arr_hard   (defuse_arr_hard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_arrays(input string tag);
    check({tag, "_easy"}, 256'(defuse_arr_easy), 256'(exp_easy));
    check({tag, "_med"},  256'(defuse_arr_medium), 256'(exp_med));
    check({tag, "_hard"}, 256'(defuse_arr_hard), 256'(exp_hard));
  endtask

  // Full request: rev_en for one cycle, then flag_done two cycles after acceptance.
  task automatic do_flag(input logic [3:0] x, input logic [3:0] y, input logic rev, input logic exp_ok);
    bus.flag_req = 1'b1;
    bus.flag_x   = x;
    bus.flag_y   = y;
    tick();
    bus.flag_req = 1'b0;
    check("lookup_rev_en", 256'(bus.rev_en), 256'(1'b1));
    check("lookup_busy", 256'(bus.busy), 256'(1'b1));
    check("lookup_rev_xy", 256'({bus.rev_x, bus.rev_y}), 256'({x, y}));
    tick();
    bus.revealed_in = rev;
    check("update_rev_en", 256'(bus.rev_en), 256'(1'b0));
    check("update_busy", 256'(bus.busy), 256'(1'b1));
    tick();
    bus.revealed_in = 1'b0;
    check("done_pulse", 256'(bus.flag_done), 256'(1'b1));
    check("done_ok", 256'(bus.flag_ok), 256'(exp_ok));
    check("done_busy", 256'(bus.busy), 256'(1'b0));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_easy = '0;
    exp_med  = '0;
    exp_hard = '0;
    rst_n = 1'b0;
    level = 2'd0;
    game_active = 1'b1;
    new_game = 1'b0;
    bus.flag_req = 1'b0;
    bus.flag_x = 4'd0;
    bus.flag_y = 4'd0;
    bus.revealed_in = 1'b0;
    tick();
    tick();
    check("rst_flags", 256'(flags_left), 256'(8'd0));
    check("rst_busy", 256'(bus.busy), 256'(1'b0));
    check("rst_done", 256'(bus.flag_done), 256'(1'b0));
    check("rst_rev_en", 256'(bus.rev_en), 256'(1'b0));
    check_arrays("rst");
    rst_n = 1'b1;
    tick();

    // Easy game: toggle on, toggle off, refuse revealed field.
    level = 2'd1;
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check("easy_budget", 256'(flags_left), 256'(8'd10));
    check("easy_busy", 256'(bus.busy), 256'(1'b0));
    tick();
    do_flag(4'd3, 4'd5, 1'b0, 1'b1);
    exp_easy[3][5] = 1'b1;
    check("set_flags", 256'(flags_left), 256'(8'd9));
    check_arrays("set");
    tick();
    check("done_one_cycle", 256'(bus.flag_done), 256'(1'b0));
    do_flag(4'd3, 4'd5, 1'b0, 1'b1);
    exp_easy[3][5] = 1'b0;
    check("clr_flags", 256'(flags_left), 256'(8'd10));
    check_arrays("clr");
    do_flag(4'd2, 4'd2, 1'b1, 1'b0);
    check("revealed_flags", 256'(flags_left), 256'(8'd10));
    check_arrays("revealed");
    tick();
    check("ok_holds", 256'(bus.flag_ok), 256'(1'b0));

    // Medium game: exhaust the 20-flag budget.
    level = 2'd2;
    tick();
    check("med_budget", 256'(flags_left), 256'(8'd20));
    for (int i = 0; i < 20; i++) begin
      do_flag(4'(i % 10), 4'(i / 10), 1'b0, 1'b1);
      exp_med[i % 10][i / 10] = 1'b1;
    end
    check("med_empty", 256'(flags_left), 256'(8'd0));
    check_arrays("med_full");
    do_flag(4'd5, 4'd5, 1'b0, 1'b0);
    check("med_21st_flags", 256'(flags_left), 256'(8'd0));
    check_arrays("med_21st");
    do_flag(4'd0, 4'd0, 1'b0, 1'b1);
    exp_med[0][0] = 1'b0;
    check("med_unflag", 256'(flags_left), 256'(8'd1));
    check_arrays("med_unflag");

    // Easy again: out-of-range request and a request while busy.
    level = 2'd1;
    exp_med = '0;
    tick();
    check("easy2_budget", 256'(flags_left), 256'(8'd10));
    check_arrays("easy2");
    bus.flag_req = 1'b1;
    bus.flag_x = 4'd9;
    bus.flag_y = 4'd0;
    tick();
    bus.flag_req = 1'b0;
    check("oor_rev_en", 256'(bus.rev_en), 256'(1'b0));
    check("oor_busy", 256'(bus.busy), 256'(1'b0));
    tick();
    tick();
    check("oor_done", 256'(bus.flag_done), 256'(1'b0));
    bus.flag_req = 1'b1;
    bus.flag_x = 4'd1;
    bus.flag_y = 4'd1;
    tick();
    bus.flag_x = 4'd2;
    bus.flag_y = 4'd2;
    tick();
    bus.flag_req = 1'b0;
    tick();
    check("busy_done", 256'(bus.flag_done), 256'(1'b1));
    exp_easy[1][1] = 1'b1;
    check_arrays("busy_req");
    tick();
    check("busy_dropped_rev_en", 256'(bus.rev_en), 256'(1'b0));
    check("busy_dropped_busy", 256'(bus.busy), 256'(1'b0));
    check("busy_flags", 256'(flags_left), 256'(8'd9));

    // Hard game: new_game aborts an in-flight request.
    level = 2'd3;
    exp_easy = '0;
    tick();
    check("hard_budget", 256'(flags_left), 256'(8'd40));
    do_flag(4'd15, 4'd15, 1'b0, 1'b1);
    exp_hard[15][15] = 1'b1;
    check("hard_set", 256'(flags_left), 256'(8'd39));
    check_arrays("hard_set");
    bus.flag_req = 1'b1;
    bus.flag_x = 4'd4;
    bus.flag_y = 4'd4;
    tick();
    bus.flag_req = 1'b0;
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    exp_hard = '0;
    check("abort_busy", 256'(bus.busy), 256'(1'b0));
    check("abort_rev_en", 256'(bus.rev_en), 256'(1'b0));
    check("abort_done", 256'(bus.flag_done), 256'(1'b0));
    check("abort_flags", 256'(flags_left), 256'(8'd40));
    check_arrays("abort");
    tick();
    check("abort_done_late", 256'(bus.flag_done), 256'(1'b0));

    // game_active dropping mid-request: in-flight completes, new one refused.
    bus.flag_req = 1'b1;
    bus.flag_x = 4'd6;
    bus.flag_y = 4'd6;
    tick();
    bus.flag_req = 1'b0;
    game_active = 1'b0;
    tick();
    tick();
    check("inactive_done", 256'(bus.flag_done), 256'(1'b1));
    check("inactive_ok", 256'(bus.flag_ok), 256'(1'b1));
    exp_hard[6][6] = 1'b1;
    check("inactive_flags", 256'(flags_left), 256'(8'd39));
    check_arrays("inactive");
    bus.flag_req = 1'b1;
    tick();
    bus.flag_req = 1'b0;
    check("inactive_refused", 256'(bus.rev_en), 256'(1'b0));
    game_active = 1'b1;

    // Reset asserted while the request sits in UPDATE.
    bus.flag_req = 1'b1;
    bus.flag_x = 4'd7;
    bus.flag_y = 4'd7;
    tick();
    bus.flag_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    exp_hard = '0;
    check("mid_rst_flags", 256'(flags_left), 256'(8'd0));
    check("mid_rst_busy", 256'(bus.busy), 256'(1'b0));
    check("mid_rst_done", 256'(bus.flag_done), 256'(1'b0));
    check("mid_rst_ok", 256'(bus.flag_ok), 256'(1'b0));
    check("mid_rst_rev", 256'({bus.rev_en, bus.rev_x, bus.rev_y}), 256'(9'd0));
    check_arrays("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_done", 256'(bus.flag_done), 256'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
